// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop.
// Operands are captured when a start request is accepted and are then added
// LSB-first, one bit per clock. After WIDTH clocks the result and carry-out
// are registered onto sum/cout and done pulses for one cycle.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a 'sub' input exists. sub=1 on accept loads ~b and forces
//   the carry-in to 1, so sum = a - b (mod 2^WIDTH) and cout = NOT borrow.
//   When undefined the block is add-only with identical timing.
//
// Parameters
//   WIDTH   operand/result width in bits, legal range 2..64 (default 8)
//
// Ports
//   clk     in   1      system clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request; sampled only when not busy (IDLE or DONE)
//   a       in   WIDTH  operand A, captured on accepted start
//   b       in   WIDTH  operand B, captured on accepted start
//   cin     in   1      carry-in, captured on accepted start
//   sub     in   1      subtract select (SERIAL_ADDER_SUB_EN only)
//   busy    out  1      high while a computation is in progress
//   done    out  1      one-cycle pulse, sum/cout valid
//   sum     out  WIDTH  registered result, changes only at completion
//   cout    out  1      registered carry-out of bit WIDTH-1
//
// Timing
//   Accept edge T0 -> RUN for edges T1..T_WIDTH -> DONE (done=1) for one
//   cycle. Holding start high in DONE re-accepts immediately, giving one
//   result every WIDTH+1 cycles.
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Bit counter only needs to reach WIDTH-1.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // op_a doubles as the result shift register: each new sum bit enters
    // at the MSB as the consumed operand bit leaves at the LSB, so after
    // WIDTH shifts op_a holds the complete sum.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // -----------------------------------------------------------------------
    // Operand conditioning on accept
    // -----------------------------------------------------------------------
`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + 1. cin is deliberately ignored.
    assign b_load     = sub ? ~b   : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    // -----------------------------------------------------------------------
    // The single full-adder cell
    // -----------------------------------------------------------------------
    assign fa_sum   = op_a[0] ^ op_b[0] ^ carry;
    assign fa_carry = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);

    // start is only honoured outside RUN; in DONE this gives back-to-back.
    assign accept   = start && (state != RUN);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: the default assignment first guarantees every path drives
    // state_nxt, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decode the registered state directly, so they are
    // glitch-free and change only on clock edges (or asynchronous reset).
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // -----------------------------------------------------------------------
    // Datapath: operand shift registers, carry FF, bit counter, outputs
    // -----------------------------------------------------------------------
    // NOTE: these are plain flip-flop registers, not a memory array, so they
    // all take the asynchronous reset; a mid-operation reset must leave no
    // stale partial result or carry behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == RUN) begin
            op_a  <= {fa_sum, op_a[WIDTH-1:1]};
            op_b  <= {1'b0, op_b[WIDTH-1:1]};
            carry <= fa_carry;
            cnt   <= cnt + CNT_W'(1);
            // sum/cout hold the previous result until the final bit is
            // known; the final bit is merged in here rather than a cycle
            // later so done and the result line up.
            if (last_bit) begin
                sum  <= {fa_sum, op_a[WIDTH-1:1]};
                cout <= fa_carry;
            end
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed testbench for serial_adder (WIDTH=8). Stimulus pushes the
// expected {cout,sum} into a scoreboard queue; an independent monitor pops
// and compares on every done pulse. Timing checks (busy duration, done
// latency, single-cycle done, result hold) are made by the stimulus thread.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] last_result = '0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                check("result", 64'({cout, sum}), 64'(exp_q.pop_front()));
            end
        end
    end

    // One operation with full timing checks. disturb=1 pulses start with
    // zero operands 3 cycles into RUN, which must be ignored.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tcin, input logic tsub,
                          input logic [WIDTH:0] expected, input bit disturb);
        bit busy_ok = 1'b1;
        bit hold_ok = 1'b1;
        @(negedge clk);
        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        exp_q.push_back(expected);
        for (int k = 1; k <= WIDTH; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                a = ~ta; b = ~tb; cin = ~tcin;   // operands must already be captured
            end
            if (disturb && k == 3) begin
                start = 1'b1; a = '0; b = '0; cin = 1'b0;
            end
            if (disturb && k == 4) start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
            if ({cout, sum} !== last_result) hold_ok = 1'b0;
        end
        check("busy_during_run", 64'(busy_ok), 64'd1);
        check("result_hold", 64'(hold_ok), 64'd1);
        @(negedge clk);
        check("done_latency", 64'({done, busy}), 64'b10);
        last_result = expected;
        @(negedge clk);
        check("done_single_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        int done_before;

        // ---- 1: reset with aggressive inputs -------------------------------
        rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_state", 64'({busy, done, cout, sum}), 64'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 64'({busy, done}), 64'd0);

        // ---- 2/3: basic additions -----------------------------------------
        run_op(8'h3C, 8'h5A, 1'b0, 1'b0, {1'b0, 8'h96}, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 8'h00}, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, {1'b1, 8'hFF}, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, {1'b0, 8'h01}, 1'b0);
        run_op(8'hAA, 8'h55, 1'b0, 1'b0, {1'b0, 8'hFF}, 1'b0);

        // ---- 4: start during RUN ignored -----------------------------------
        run_op(8'h12, 8'h34, 1'b1, 1'b0, {1'b0, 8'h47}, 1'b1);

        // ---- back-to-back: start held high through DONE --------------------
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        exp_q.push_back({1'b1, 8'h00});
        @(negedge clk);
        a = 8'h01; b = 8'h7F; cin = 1'b1;   // captured at the DONE re-accept
        exp_q.push_back({1'b0, 8'h81});
        repeat (WIDTH - 1) @(negedge clk);
        check("b2b_busy1", 64'({busy, done}), 64'b10);
        @(negedge clk);
        check("b2b_done1", 64'({busy, done}), 64'b01);
        @(negedge clk);
        check("b2b_reaccept", 64'({busy, done}), 64'b10);
        start = 1'b0;
        repeat (WIDTH - 1) @(negedge clk);
        check("b2b_busy2", 64'({busy, done}), 64'b10);
        @(negedge clk);
        check("b2b_done2", 64'({busy, done}), 64'b01);
        @(negedge clk);
        check("b2b_idle", 64'({busy, done}), 64'b00);
        last_result = {1'b0, 8'h81};

        // ---- 5: reset mid-RUN aborts ---------------------------------------
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        done_before = n_done;
        rst_n = 1'b0;
        #1;
        check("abort_state", 64'({busy, done, cout, sum}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 3) @(negedge clk);
        check("abort_no_done", 64'(n_done), 64'(done_before));
        last_result = '0;
        run_op(8'h3C, 8'h5A, 1'b0, 1'b0, {1'b0, 8'h96}, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        // ---- 6: subtract mode ----------------------------------------------
        run_op(8'h10, 8'h03, 1'b0, 1'b1, {1'b1, 8'h0D}, 1'b0);
        run_op(8'h03, 8'h10, 1'b1, 1'b1, {1'b0, 8'hF3}, 1'b0);
        run_op(8'h10, 8'h03, 1'b0, 1'b0, {1'b0, 8'h13}, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d tests expected completion", n_tests);
        $fatal(1, "timeout");
    end

endmodule
